mips_alu_md: RTL and testbench
==============================

Name: mips_alu_md

Overview:
- Registered, handshaked ALU for the MIPS execute stage, parametrised in data width.
- Extends the basic add/NOP ALU with:
  - the full R-type logic, shift and compare set;
  - an iterative unsigned multiply/divide unit with architectural HI/LO registers;
  - valid/ready flow control, so the pipeline can stall on long operations.
- The decoder maps ADDIU, LW and SW address generation to the ADDU function code.

Parameters:
- WIDTH, 32: operand, result, HI and LO width. Must be a power of two and at least 8.
- SHW, 5: shift-amount width, equal to log2(WIDTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- funct  in  6  MIPS function code
- op1  in  WIDTH  rs operand (unsigned)
- op2  in  WIDTH  rt operand (unsigned)
- shamt  in  SHW  shift amount
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- data_out  out  WIDTH  result
- illegal  out  1  result corresponds to an unsupported funct; qualified by out_valid
- hi  out  WIDTH  HI register, continuous view
- lo  out  WIDTH  LO register, continuous view

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low.
  - While rst_n = 0: state = IDLE; out_valid, data_out, illegal, hi, lo, counter and internal accumulators all = 0.
  - in_ready = 0 while rst_n = 0, and 1 in the first cycle after release.
  - Reset asserted mid-operation aborts the operation; HI/LO do not keep partial values.
- Handshake:
  - A request is accepted on a rising edge where in_valid and in_ready are both 1.
  - A result is consumed on a rising edge where out_valid and out_ready are both 1.
  - in_ready = (state==IDLE) or (state==DONE and out_ready).
  - This gives back-to-back single-cycle operations at one per cycle.
  - data_out and illegal hold stable while out_valid = 1 and out_ready = 0.
- States:
  - IDLE: on accept, a single-cycle op goes to DONE; MULTU goes to MUL; DIVU goes to DIV.
  - MUL / DIV: run exactly WIDTH iterations, counting WIDTH-1 down to 0, then go to DONE.
  - DONE: out_valid = 1.
    - On consume with a new accept, go directly to the state for the new op.
    - On consume without a new accept, go to IDLE.
    - Without consume, stay in DONE.
- Single-cycle ops (result registered; out_valid on the edge after acceptance; latency 1). Arithmetic is modulo 2^WIDTH with no overflow traps:
  - ADDU 100001: op1+op2
  - SUBU 100011: op1-op2
  - AND 100100; OR 100101; XOR 100110; NOR 100111
  - SLT 101010: signed compare, result 1 or 0
  - SLTU 101011: unsigned compare, result 1 or 0
  - SLL 000000: op2<<shamt
  - SRL 000010: logical right shift of op2 by shamt
  - SRA 000011: arithmetic right shift of op2 by shamt
  - funct 000000 with shamt 0 and op2 0 gives 0, so NOP needs no special case.
  - MFHI 010000: data_out = hi
  - MFLO 010010: data_out = lo
  - MTHI 010001: hi <= op1, data_out = 0
  - MTLO 010011: lo <= op1, data_out = 0
  - Any other funct: data_out = 0, illegal = 1, HI/LO unchanged.
- MULTU 011001:
  - Shift-add, one multiplier bit per cycle.
  - On entry to DONE: {hi,lo} = full 2*WIDTH-bit product; data_out = 0.
  - out_valid rises WIDTH+1 edges after acceptance.
- DIVU 011011:
  - Restoring division, one quotient bit per cycle; same latency as MULTU.
  - On entry to DONE: lo = quotient, hi = remainder.
  - Divide by zero: lo = all ones, hi = op1, same latency, illegal = 0.
- HI/LO visibility:
  - MUL/DIV operands are captured at acceptance; later changes on op1/op2 have no effect.
  - hi/lo ports change only on entry to DONE for MULTU/DIVU, or on the edge after acceptance for MTHI/MTLO.
  - MFHI/MFLO accepted in the same edge as the consume of a MULTU result see the new HI/LO.

Test Plan:
- Reset then ADDU op1=32'hFFFF_FFFF, op2=2, out_ready=1 -> next cycle out_valid=1, data_out=1, illegal=0.
- Back-to-back with in_valid and out_ready held high: SUBU 5-7, SLT 32'h8000_0000 vs 1, SRA 32'h8000_0000 by 4 -> results on three consecutive cycles: FFFF_FFFE, 1, F800_0000.
- MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> out_valid exactly 33 edges after accept; hi=FFFF_FFFE, lo=0000_0001. Then MFHI -> FFFF_FFFE.
- DIVU 100/7 -> lo=14, hi=2. DIVU 9/0 -> lo=FFFF_FFFF, hi=9. Both with 33-cycle latency.
- out_ready=0 for 5 cycles after an AND result -> data_out stable, in_ready=0, no new request accepted. On release, consume and accept on the same edge.
- Assert rst_n low during a MULTU (iteration 10) -> all outputs 0 immediately. After release: in_ready=1, hi=lo=0.
- funct=111111 -> illegal=1, data_out=0, HI/LO unchanged.

Source files
------------

// File: rtl/mips_alu_md.sv
// mips_alu_md: registered, handshaked MIPS execute-stage ALU with an
// iterative unsigned multiply/divide unit and architectural HI/LO registers.
module mips_alu_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    state_t           state;
    state_t           state_next;
    state_t           accept_target;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] alu_result;
    logic             alu_illegal;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic             accept;
    logic             consume;
    logic             last_step;

    assign out_valid = (state == DONE);
    assign in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign last_step = (count == '0);

    // Decode funct into a single-cycle result, legality flag and the state to enter on accept
    always_comb begin
        alu_result    = '0;
        alu_illegal   = 1'b0;
        accept_target = DONE;
        case (funct)
            F_ADDU:  alu_result = op1 + op2;
            F_SUBU:  alu_result = op1 - op2;
            F_AND:   alu_result = op1 & op2;
            F_OR:    alu_result = op1 | op2;
            F_XOR:   alu_result = op1 ^ op2;
            F_NOR:   alu_result = ~(op1 | op2);
            F_SLT:   alu_result = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            F_SLTU:  alu_result = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            F_SLL:   alu_result = op2 << shamt;
            F_SRL:   alu_result = op2 >> shamt;
            F_SRA:   alu_result = $signed(op2) >>> shamt;
            F_MFHI:  alu_result = hi;
            F_MFLO:  alu_result = lo;
            F_MTHI:  alu_result = '0;
            F_MTLO:  alu_result = '0;
            F_MULTU: accept_target = MUL;
            F_DIVU:  accept_target = DIV;
            default: alu_illegal = 1'b1;
        endcase
    end

    // One shift-add (multiply) or restoring-subtract (divide) step on the shared accumulator pair
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        div_ge    = (div_shift >= {1'b0, operand});
        if (state == DIV) begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Next-state logic: iterate in MUL/DIV, hold DONE until consumed, chain straight into a new op
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = accept_target;
            MUL,
            DIV:     if (last_step) state_next = DONE;
            DONE:    if (consume) state_next = accept ? accept_target : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Datapath: capture operands on accept, step the iterative unit, publish results and HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            operand  <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            data_out <= '0;
            illegal  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (accept) begin
            if (accept_target == DONE) begin
                data_out <= alu_result;
                illegal  <= alu_illegal;
                if (funct == F_MTHI) hi <= op1;
                if (funct == F_MTLO) lo <= op1;
            end else begin
                operand <= op2;
                acc_hi  <= '0;
                acc_lo  <= op1;
                count   <= SHW'(WIDTH - 1);
            end
        end else if ((state == MUL) || (state == DIV)) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            count  <= count - 1'b1;
            if (last_step) begin
                hi       <= step_hi;
                lo       <= step_lo;
                data_out <= '0;
                illegal  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_alu_md.sv
// tb_mips_alu_md: scoreboard bench for mips_alu_md with directed and random traffic.
module tb_mips_alu_md;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       funct;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             illegal;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    typedef struct {
        logic [31:0] data;
        logic        ill;
        logic [31:0] hi;
        logic [31:0] lo;
        int          acc_cycle;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cycle = 0;
    int          first_seen = -1;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit          rand_phase = 1'b0;

    mips_alu_md #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .op1       (op1),
        .op2       (op2),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .illegal   (illegal),
        .hi        (hi),
        .lo        (lo)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used for latency measurement
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Architectural reference: plain arithmetic on the MIPS rules, updates model HI/LO in program order
    function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh);
        exp_t            e;
        logic [63:0]     prod;
        int              sa;
        int              sbv;
        e.data = '0;
        e.ill  = 1'b0;
        e.lat  = 1;
        e.acc_cycle = 0;
        sa  = a;
        sbv = b;
        case (f)
            F_ADDU:  e.data = a + b;
            F_SUBU:  e.data = a - b;
            F_AND:   e.data = a & b;
            F_OR:    e.data = a | b;
            F_XOR:   e.data = a ^ b;
            F_NOR:   e.data = ~(a | b);
            F_SLT:   e.data = (sa < sbv) ? 32'd1 : 32'd0;
            F_SLTU:  e.data = (a < b) ? 32'd1 : 32'd0;
            F_SLL:   e.data = b << sh;
            F_SRL:   e.data = b >> sh;
            F_SRA:   e.data = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            F_MFHI:  e.data = m_hi;
            F_MFLO:  e.data = m_lo;
            F_MTHI:  m_hi = a;
            F_MTLO:  m_lo = a;
            F_MULTU: begin
                prod  = {32'h0, a} * {32'h0, b};
                m_hi  = prod[63:32];
                m_lo  = prod[31:0];
                e.lat = 33;
            end
            F_DIVU: begin
                if (b == 32'h0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                e.lat = 33;
            end
            default: e.ill = 1'b1;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        return e;
    endfunction

    // Issue one request, wait (bounded) for acceptance, then push its expected response
    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
        bit   r;
        bit   ok;
        exp_t e;
        ok       = 1'b0;
        funct    = f;
        op1      = a;
        op2      = b;
        shamt    = sh;
        in_valid = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (ok) begin
            e = model(f, a, b, sh);
            e.acc_cycle = cycle;
            sb.push_back(e);
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout funct=%h: got in_ready=0 expected 1", f);
        end
    endtask

    // Wait (bounded) until every issued request has been consumed
    task automatic waitDrain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: on every consume, pop the scoreboard and compare result, flags, HI/LO and latency
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (first_seen < 0) first_seen = cycle;
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_output: got data_out=%h expected none", data_out);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("data_out", data_out, e.data);
                        checkOutput("illegal", {31'b0, illegal}, {31'b0, e.ill});
                        checkOutput("hi", hi, e.hi);
                        checkOutput("lo", lo, e.lo);
                        checkOutput("latency", 32'(first_seen - e.acc_cycle + 1), 32'(e.lat));
                    end
                    first_seen = -1;
                end
            end
        end
    end

    // Random back-pressure during the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_phase) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed cases, stall, random, reset mid-multiply
    initial begin
        logic [5:0] ops [17];
        logic [5:0] f;
        logic [31:0] a;
        logic [31:0] b;
        int c0;
        ops = '{F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU, F_SLL, F_SRL,
                F_SRA, F_MFHI, F_MFLO, F_MTHI, F_MTLO, F_MULTU, F_DIVU};
        in_valid  = 1'b0;
        funct     = '0;
        op1       = '0;
        op2       = '0;
        shamt     = '0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'h0);
        checkOutput("reset_data_out", data_out, 32'h0);
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;

        $display("[TB] directed single-cycle ops");
        applyStimulus(F_ADDU, 32'hFFFF_FFFF, 32'h2, 5'd0);
        c0 = cycle;
        applyStimulus(F_SUBU, 32'd5, 32'd7, 5'd0);
        applyStimulus(F_SLT, 32'h8000_0000, 32'h1, 5'd0);
        applyStimulus(F_SRA, 32'h0, 32'h8000_0000, 5'd4);
        checkOutput("b2b_cycles", 32'(cycle - c0), 32'd3);
        waitDrain();

        $display("[TB] multiply and divide");
        applyStimulus(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        applyStimulus(F_MFHI, 32'h0, 32'h0, 5'd0);
        applyStimulus(F_DIVU, 32'd100, 32'd7, 5'd0);
        applyStimulus(F_DIVU, 32'd9, 32'd0, 5'd0);
        waitDrain();

        $display("[TB] output stall");
        out_ready = 1'b0;
        applyStimulus(F_AND, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 5'd0);
        fork
            applyStimulus(F_ADDU, 32'd10, 32'd20, 5'd0);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    checkOutput("stall_out_valid", {31'b0, out_valid}, 32'h1);
                    checkOutput("stall_data_out", data_out, 32'h3030_3030);
                    checkOutput("stall_in_ready", {31'b0, in_ready}, 32'h0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] illegal funct");
        applyStimulus(6'h3F, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
        waitDrain();

        $display("[TB] random traffic");
        rand_phase = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 19) < 17) f = ops[$urandom_range(0, 16)];
            else f = 6'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (f == F_DIVU && $urandom_range(0, 5) == 0) b = 32'h0;
            applyStimulus(f, a, b, 5'($urandom));
        end
        rand_phase = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        waitDrain();

        $display("[TB] reset during multiply");
        applyStimulus(F_MTHI, 32'hDEAD_BEEF, 32'h0, 5'd0);
        applyStimulus(F_MTLO, 32'hCAFE_F00D, 32'h0, 5'd0);
        applyStimulus(F_ADDU, 32'd1, 32'd1, 5'd0);
        waitDrain();
        applyStimulus(F_MULTU, 32'd3, 32'd5, 5'd0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("abort_in_ready", {31'b0, in_ready}, 32'h0);
        checkOutput("abort_data_out", data_out, 32'h0);
        checkOutput("abort_illegal", {31'b0, illegal}, 32'h0);
        checkOutput("abort_hi", hi, 32'h0);
        checkOutput("abort_lo", lo, 32'h0);
        sb.delete();
        first_seen = -1;
        m_hi = '0;
        m_lo = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rerelease_in_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("rerelease_hi", hi, 32'h0);
        checkOutput("rerelease_lo", lo, 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(F_MFLO, 32'h0, 32'h0, 5'd0);
        applyStimulus(F_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 5'd0);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
